// File: rtl/jk_counter_pkg.sv
// Shared encodings for the JK counter controller: FSM states and per-stage
// {J,K} command codes.
package jk_counter_pkg;

  // 2'b11 is unused; the controller steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t HOLD = 2'b00;
  localparam jk_cmd_t CLR  = 2'b01;
  localparam jk_cmd_t SET  = 2'b10;
  localparam jk_cmd_t TOG  = 2'b11;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Control/status bundle between system control logic (master) and the JK
// counter controller (slave); state_dbg exposes the FSM for checkers.
//
// Handshake: there is no valid/ready pair. start/stop/load/dir/oneshot are
// levels sampled on every rising clk edge; q/tc/busy/state_dbg are registered
// and valid from the edge that produced them.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  import jk_counter_pkg::*;

  logic             start;
  logic             stop;
  logic             dir;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  state_t           state_dbg;

  modport master (
    output start, stop, dir, oneshot, load, load_val,
    input  q, tc, busy, state_dbg
  );

  modport slave (
    input  start, stop, dir, oneshot, load, load_val,
    output q, tc, busy, state_dbg
  );

endinterface

// File: rtl/jk_stage.sv
// One JK flip-flop stage of the counter bank, asynchronously cleared to 0.
module jk_stage
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        HOLD:    q <= q;
        CLR:     q <= 1'b0;
        SET:     q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Start/stop, up/down, modulo-MOD counter controller. Every q update is made
// by steering the J/K inputs of a WIDTH-bit bank of jk_stage flops.
module jk_counter_ctrl
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input logic          clk,
  input logic          rst_n,
  jk_counter_ctrl_if.slave bus
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] load_tgt;
  logic             count_en;
  logic             wrap;
  logic             busy;
  logic             tc_q;

  // Counting happens only in RUN and only when load/stop do not claim the edge.
  assign count_en = (state == RUN) && !bus.load && !bus.stop;
  assign wrap     = count_en && (bus.dir ? (q == MAX_VAL) : (q == '0));
  assign load_tgt = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!bus.load && !bus.stop && bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (bus.load)                    state_nxt = RUN;
        else if (bus.stop)               state_nxt = IDLE;
        else if (wrap && bus.oneshot)    state_nxt = DONE;
      end
      DONE: begin
        if (bus.load || bus.stop)        state_nxt = IDLE;
        else if (bus.start)              state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-bit J/K mux: load > wrap target > ripple toggle > hold.
  always_comb begin
    jk_cmd_t c;
    logic    carry_up;
    logic    carry_dn;
    busy     = (state == RUN);
    j_vec    = '0;
    k_vec    = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    c        = HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      c = HOLD;
      if (bus.load) begin
        c = load_tgt[i] ? SET : CLR;
      end else if (count_en) begin
        if (wrap) begin
          if (bus.dir) c = q[i] ? CLR : HOLD;
          else         c = MAX_VAL[i] ? SET : CLR;
        end else if (bus.dir) begin
          c = carry_up ? TOG : HOLD;
        end else begin
          c = carry_dn ? TOG : HOLD;
        end
      end
      j_vec[i] = c[1];
      k_vec[i] = c[0];
      carry_up = carry_up & q[i];
      carry_dn = carry_dn & qbar[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= wrap;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_stage u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j_vec[g]),
      .k    (k_vec[g]),
      .q    (q[g]),
      .qbar (qbar[g])
    );
  end

  assign bus.q         = q;
  assign bus.tc        = tc_q;
  assign bus.busy      = busy;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: directed scenarios plus random stimulus checked
// against an arithmetic reference model (MOD=10), and a MOD=16 roll-over case.
module tb_jk_counter_ctrl;
  import jk_counter_pkg::*;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  jk_counter_ctrl_if #(.WIDTH(WIDTH)) bus10 ();
  jk_counter_ctrl_if #(.WIDTH(WIDTH)) bus16 ();

  jk_counter_ctrl #(.WIDTH(WIDTH), .MOD(MOD)) dut10 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus10)
  );

  jk_counter_ctrl #(.WIDTH(WIDTH), .MOD(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  // reference model + scoreboard
  int               m_q;
  state_t           m_st;
  bit               m_tc;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q  = 0;
    m_st = IDLE;
    m_tc = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit w;
    w    = 0;
    m_tc = 0;
    if (bus10.load) begin
      m_q = (int'(bus10.load_val) < MOD) ? int'(bus10.load_val) : 0;
      if (m_st == DONE) m_st = IDLE;
    end else if (bus10.stop) begin
      m_st = IDLE;
    end else if (m_st != RUN && bus10.start) begin
      m_st = RUN;
    end else if (m_st == RUN) begin
      if (bus10.dir) begin
        w   = (m_q == MOD - 1);
        m_q = (m_q + 1) % MOD;
      end else begin
        w   = (m_q == 0);
        m_q = (m_q + MOD - 1) % MOD;
      end
      if (w) begin
        m_tc = 1;
        if (bus10.oneshot) m_st = DONE;
      end
    end
    exp_q.push_back(WIDTH'(m_q));
  endtask

  // driver tasks
  task automatic drive(input bit st, input bit sp, input bit d, input bit os,
                       input bit ld, input logic [WIDTH-1:0] lv);
    bus10.start    = st;
    bus10.stop     = sp;
    bus10.dir      = d;
    bus10.oneshot  = os;
    bus10.load     = ld;
    bus10.load_val = lv;
  endtask

  task automatic tick();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("q", 32'(bus10.q), 32'(e));
    check("busy", 32'(bus10.busy), 32'(m_st == RUN));
    check("tc", 32'(bus10.tc), 32'(m_tc));
    check("state", 32'(bus10.state_dbg), 32'(m_st));
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 1, 0, 0, '0);
    bus16.start = 0; bus16.stop = 0; bus16.dir = 1; bus16.oneshot = 0;
    bus16.load = 0; bus16.load_val = '0;
    model_reset();
    #12;
    check("rst_q", 32'(bus10.q), 0);
    check("rst_busy", 32'(bus10.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-count at q=6
    drive(1, 0, 1, 0, 0, '0);
    tick();
    drive(0, 0, 1, 0, 0, '0);
    repeat (6) tick();
    check("pre_rst_q", 32'(bus10.q), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(bus10.q), 0);
    check("async_rst_busy", 32'(bus10.busy), 0);
    check("async_rst_tc", 32'(bus10.tc), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_hold", 32'(bus10.q), 0);

    // free-run up, start held high the whole time
    drive(1, 0, 1, 0, 0, '0);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("fr_seq", 32'(bus10.q), 32'((i + 1) % 10));
      check("fr_tc", 32'(bus10.tc), 32'(i == 9));
      check("fr_busy", 32'(bus10.busy), 1);
    end
    drive(0, 1, 1, 0, 0, '0);
    tick();

    // down with wrap, oneshot
    drive(0, 0, 0, 1, 1, 4'd2);
    tick();
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    tick(); check("dn_1", 32'(bus10.q), 1);
    tick(); check("dn_0", 32'(bus10.q), 0);
    tick(); check("dn_9", 32'(bus10.q), 9);
    check("dn_tc", 32'(bus10.tc), 1);
    check("dn_done", 32'(bus10.state_dbg), 32'(DONE));
    tick(); tick();
    check("done_hold", 32'(bus10.q), 9);
    drive(1, 0, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 1, 0, '0);
    tick(); check("resume_8", 32'(bus10.q), 8);
    tick(); check("resume_7", 32'(bus10.q), 7);

    // priority: load beats stop and start
    repeat (3) tick();
    check("pri_pre", 32'(bus10.q), 4);
    drive(1, 1, 0, 0, 1, 4'd7);
    tick();
    check("pri_q", 32'(bus10.q), 7);
    check("pri_run", 32'(bus10.state_dbg), 32'(RUN));
    drive(0, 1, 0, 0, 0, '0);
    tick();
    check("pri_idle", 32'(bus10.state_dbg), 32'(IDLE));

    // out-of-range load
    drive(0, 0, 1, 0, 1, 4'd12);
    tick();
    check("oor_load", 32'(bus10.q), 0);

    // dir reversal through the down wrap
    drive(1, 0, 1, 0, 0, '0);
    tick();
    drive(0, 0, 1, 0, 0, '0);
    repeat (3) tick();
    check("rev_up3", 32'(bus10.q), 3);
    drive(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rev_seq", 32'(bus10.q), 32'((i < 3) ? (2 - i) : 9));
      check("rev_tc", 32'(bus10.tc), 32'(i == 3));
    end
    drive(0, 1, 0, 0, 0, '0);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
      tick();
    end

    // full-range modulus: natural binary roll-over
    bus16.load = 1; bus16.load_val = 4'd15;
    @(posedge clk); #1;
    check("m16_load", 32'(bus16.q), 15);
    @(negedge clk);
    bus16.load = 0; bus16.start = 1; bus16.dir = 1;
    @(posedge clk); #1;
    check("m16_busy", 32'(bus16.busy), 1);
    check("m16_hold", 32'(bus16.q), 15);
    @(negedge clk);
    bus16.start = 0;
    @(posedge clk); #1;
    check("m16_wrap", 32'(bus16.q), 0);
    check("m16_tc", 32'(bus16.tc), 1);
    @(posedge clk); #1;
    check("m16_next", 32'(bus16.q), 1);
    check("m16_tc_low", 32'(bus16.tc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
